// File: rtl/buffer_ctrl_pkg.sv
// Shared definitions for the buffer RAM controllers (FIFO-to-RAM and RAM-to-FIFO).
// Holds the state encoding, the default bus widths and the RAM depth.
package buffer_ctrl_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_CNT_W     = 9;
    localparam int DEF_MAX_WORDS = 256;

    // Legacy-compatible state encoding shared by both controllers
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAITQ = 3'd2;
    localparam logic [2:0] ST_PUSH  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/write_control_logic_if.sv
// Control, RAM read port and FIFO write port of the RAM-to-FIFO write controller.
// The master modport is the controller; the slave modport is its environment.
interface write_control_logic_if
    import buffer_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) ();

    logic              start_i;
    logic              abort_i;
    logic [CNT_W-1:0]  word_count_i;
    logic [DATA_W-1:0] ram_q_i;
    logic              wrfull_i;
    logic              rden_o;
    logic [ADDR_W-1:0] addr_o;
    logic              wrreq_o;
    logic [DATA_W-1:0] data_o;
    logic              busy_o;
    logic              done_o;
    logic [CNT_W-1:0]  words_sent_o;

    modport master (
        input  start_i, abort_i, word_count_i, ram_q_i, wrfull_i,
        output rden_o, addr_o, wrreq_o, data_o, busy_o, done_o, words_sent_o
    );

    modport slave (
        output start_i, abort_i, word_count_i, ram_q_i, wrfull_i,
        input  rden_o, addr_o, wrreq_o, data_o, busy_o, done_o, words_sent_o
    );

endinterface

// File: rtl/write_control_logic.sv
// Drains words 0..N-1 of the buffer RAM into the FIFO write port, one read outstanding
// at a time, honouring FIFO full and the RAM read latency.
module write_control_logic
    import buffer_ctrl_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MAX_WORDS   = DEF_MAX_WORDS,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    write_control_logic_if.master bus
);

    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_WORDS);
    localparam logic [1:0]       C_LAT     = 2'(RAM_LATENCY);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_words_sent;
    logic [CNT_W-1:0]  r_target;
    logic [1:0]        r_lat_cnt;

    logic [CNT_W-1:0]  w_clamped;
    logic              w_last;
    logic              w_push;

    // Clamping the count keeps addr_o inside the RAM, so it can never wrap.
    assign w_clamped = (bus.word_count_i > C_MAX_CNT) ? C_MAX_CNT : bus.word_count_i;
    assign w_last    = (r_words_sent + CNT_W'(1)) == r_target;

    // NOTE: wrreq is gated combinationally by wrfull_i, so a push into a full FIFO cannot occur.
    assign w_push    = (r_state == ST_PUSH) && !bus.wrfull_i && !bus.abort_i;

    assign bus.rden_o       = (r_state == ST_READ);
    assign bus.wrreq_o      = w_push;
    assign bus.busy_o       = (r_state == ST_READ) || (r_state == ST_WAITQ) || (r_state == ST_PUSH);
    assign bus.done_o       = (r_state == ST_DONE) && !bus.abort_i;
    assign bus.addr_o       = r_addr;
    assign bus.data_o       = r_data;
    assign bus.words_sent_o = r_words_sent;

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_data       <= '0;
            r_words_sent <= '0;
            r_target     <= '0;
            r_lat_cnt    <= '0;
        end else if (r_state == ST_IDLE) begin
            if (bus.start_i && !bus.abort_i) begin
                r_words_sent <= '0;
                if (bus.word_count_i != '0) begin
                    r_target <= w_clamped;
                    r_addr   <= '0;
                    r_state  <= ST_READ;
                end else begin
                    r_state  <= ST_DONE;
                end
            end
        end else if (bus.abort_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_READ: begin
                    r_lat_cnt <= C_LAT;
                    r_state   <= ST_WAITQ;
                end
                ST_WAITQ: begin
                    if (r_lat_cnt == 2'd1) begin
                        r_data  <= bus.ram_q_i;
                        r_state <= ST_PUSH;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 2'd1;
                    end
                end
                ST_PUSH: begin
                    if (!bus.wrfull_i) begin
                        r_words_sent <= r_words_sent + CNT_W'(1);
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_state <= ST_READ;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
